// File: rtl/bip2_control_unit_pkg.sv
// Shared constants for the BIP-2 control unit: opcodes, accumulator source
// encodings, FSM state codes and default field widths.
package bip2_pkg;

  localparam int OPCODE_W_DEF = 5;
  localparam int ADDR_W_DEF   = 11;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BGT  = 5'b01010;
  localparam logic [4:0] OP_BGE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BLE  = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;

  localparam logic [1:0] ACC_SRC_ALU = 2'b00;
  localparam logic [1:0] ACC_SRC_RAM = 2'b01;
  localparam logic [1:0] ACC_SRC_IMM = 2'b10;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/bip2_control_unit_if.sv
// Instruction/flag inputs and datapath strobes between the BIP-2 control unit
// (master) and the PC/datapath/memory side (slave).
interface bip2_control_unit_if
  import bip2_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) ();

  logic [OPCODE_W+ADDR_W-1:0] instr_i;
  logic                       status_z_i;
  logic                       status_n_i;
  logic                       ir_load_o;
  logic                       pc_enable_o;
  logic                       pc_sel_o;
  logic                       acc_write_o;
  logic [1:0]                 acc_src_o;
  logic                       alu_sub_o;
  logic                       alu_src_o;
  logic                       ram_write_o;
  logic                       status_write_o;
  logic                       halted_o;

  modport master (
    input  instr_i, status_z_i, status_n_i,
    output ir_load_o, pc_enable_o, pc_sel_o, acc_write_o, acc_src_o,
           alu_sub_o, alu_src_o, ram_write_o, status_write_o, halted_o
  );

  modport slave (
    output instr_i, status_z_i, status_n_i,
    input  ir_load_o, pc_enable_o, pc_sel_o, acc_write_o, acc_src_o,
           alu_sub_o, alu_src_o, ram_write_o, status_write_o, halted_o
  );

endinterface

// File: rtl/bip2_control_unit_branch_eval.sv
// Branch condition evaluation from opcode and STATUS Z/N flags; purely combinational.
// Non-branch opcodes never report taken; JMP always does.
module bip2_branch_eval
  import bip2_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                z_i,
  input  logic                n_i,
  output logic                taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OP_BEQ:  taken_o = z_i;
      OP_BNE:  taken_o = ~z_i;
      OP_BGT:  taken_o = ~z_i & ~n_i;
      OP_BGE:  taken_o = ~n_i;
      OP_BLT:  taken_o = n_i;
      OP_BLE:  taken_o = n_i | z_i;
      OP_JMP:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip2_control_unit.sv
// BIP-2 two-cycle control FSM (FETCH -> EXEC, HLT -> HALT until reset).
// Optional BIP2_SINGLE_STEP_EN adds step_i, which gates each FETCH.
module bip2_control_unit
  import bip2_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
`ifdef BIP2_SINGLE_STEP_EN
  input  logic                step_i,
`endif
  bip2_control_unit_if.master bus
);

  logic [1:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                fetch_go;
  logic                taken;
  logic [ADDR_W-1:0]   unused_operand;

  logic       ir_load, pc_enable, pc_sel, acc_write;
  logic [1:0] acc_src;
  logic       alu_sub, alu_src, ram_write, status_write, halted;

`ifdef BIP2_SINGLE_STEP_EN
  assign fetch_go = step_i;
`else
  assign fetch_go = 1'b1;
`endif

  // Operand bits go straight to the PC/datapath; the FSM only needs the opcode.
  assign unused_operand = bus.instr_i[ADDR_W-1:0];

  bip2_branch_eval #(.OPCODE_W(OPCODE_W)) u_branch_eval (
    .opcode_i (opcode_q),
    .z_i      (bus.status_z_i),
    .n_i      (bus.status_n_i),
    .taken_o  (taken)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_go) begin
          opcode_d = bus.instr_i[OPCODE_W+ADDR_W-1 -: OPCODE_W];
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC:  state_d = (opcode_q == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    ir_load      = 1'b0;
    pc_enable    = 1'b0;
    pc_sel       = 1'b0;
    acc_write    = 1'b0;
    acc_src      = ACC_SRC_ALU;
    alu_sub      = 1'b0;
    alu_src      = 1'b0;
    ram_write    = 1'b0;
    status_write = 1'b0;
    halted       = 1'b0;
    case (state_q)
      // Reset forces FETCH, so gate the strobe to keep all outputs low while held.
      ST_FETCH: ir_load = fetch_go & reset_n_i;
      ST_EXEC: begin
        if (opcode_q != OP_HLT) begin
          pc_enable = 1'b1;
          pc_sel    = taken;
        end
        case (opcode_q)
          OP_STO: ram_write = 1'b1;
          OP_LD: begin
            acc_write = 1'b1;
            acc_src   = ACC_SRC_RAM;
          end
          OP_LDI: begin
            acc_write = 1'b1;
            acc_src   = ACC_SRC_IMM;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            acc_write    = 1'b1;
            acc_src      = ACC_SRC_ALU;
            status_write = 1'b1;
            alu_src      = opcode_q[0];
            alu_sub      = opcode_q[1];
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.ir_load_o      = ir_load;
  assign bus.pc_enable_o    = pc_enable;
  assign bus.pc_sel_o       = pc_sel;
  assign bus.acc_write_o    = acc_write;
  assign bus.acc_src_o      = acc_src;
  assign bus.alu_sub_o      = alu_sub;
  assign bus.alu_src_o      = alu_src;
  assign bus.ram_write_o    = ram_write;
  assign bus.status_write_o = status_write;
  assign bus.halted_o       = halted;

endmodule

// File: tb/tb_bip2_control_unit.sv
// Self-checking bench for bip2_control_unit: opcode vector table, branch sweep,
// reset mid-EXEC, a short program run and (when enabled) single-step gating.
module tb_bip2_control_unit;
  import bip2_pkg::*;

  // Output vector: ir_load, pc_en, pc_sel, acc_wr, acc_src[1:0], alu_sub, alu_src, ram_wr, st_wr, halted
  localparam logic [10:0] V_ZERO  = 11'b0_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] V_FETCH = 11'b1_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] V_NOP   = 11'b0_1_0_0_00_0_0_0_0_0;
  localparam logic [10:0] V_JUMP  = 11'b0_1_1_0_00_0_0_0_0_0;
  localparam logic [10:0] V_STO   = 11'b0_1_0_0_00_0_0_1_0_0;
  localparam logic [10:0] V_LD    = 11'b0_1_0_1_01_0_0_0_0_0;
  localparam logic [10:0] V_LDI   = 11'b0_1_0_1_10_0_0_0_0_0;
  localparam logic [10:0] V_ADD   = 11'b0_1_0_1_00_0_0_0_1_0;
  localparam logic [10:0] V_ADDI  = 11'b0_1_0_1_00_0_1_0_1_0;
  localparam logic [10:0] V_SUB   = 11'b0_1_0_1_00_1_0_0_1_0;
  localparam logic [10:0] V_SUBI  = 11'b0_1_0_1_00_1_1_0_1_0;
  localparam logic [10:0] V_HALT  = 11'b0_0_0_0_00_0_0_0_0_1;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [10:0] operand;
    logic        z;
    logic        n;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  bip2_control_unit_if bus ();

  bip2_control_unit dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
`ifdef BIP2_SINGLE_STEP_EN
    .step_i    (step),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {bus.ir_load_o, bus.pc_enable_o, bus.pc_sel_o, bus.acc_write_o, bus.acc_src_o,
            bus.alu_sub_o, bus.alu_src_o, bus.ram_write_o, bus.status_write_o, bus.halted_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; leaves at the falling edge after EXEC.
  task automatic exec_instr(input string name, input logic [4:0] op, input logic [10:0] operand,
                            input logic z, input logic n, input logic [10:0] exp);
    exp_t e;
    bus.instr_i    = {op, operand};
    bus.status_z_i = z;
    bus.status_n_i = n;
    #1;
    check({name, "_fetch"}, {21'd0, outs()}, {21'd0, V_FETCH});
    sb_q.push_back('{name, exp});
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_exec"}, {21'd0, outs()}, {21'd0, e.vec});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t        vecs[12];
    logic [2:0]  taken_tbl[6];
    logic [10:0] prog[4];
    logic [10:0] exp_prog[12];
    logic [4:0]  prog_op[4];
    logic [1:0]  zn_tbl[3];
    int          pcen_cnt;

    vecs[0]  = '{"STO",     OP_STO,  11'h010, 1'b0, 1'b0, V_STO};
    vecs[1]  = '{"LD",      OP_LD,   11'h123, 1'b0, 1'b0, V_LD};
    vecs[2]  = '{"LDI",     OP_LDI,  11'h005, 1'b1, 1'b1, V_LDI};
    vecs[3]  = '{"ADD",     OP_ADD,  11'h020, 1'b0, 1'b0, V_ADD};
    vecs[4]  = '{"ADDI",    OP_ADDI, 11'h003, 1'b0, 1'b1, V_ADDI};
    vecs[5]  = '{"SUB",     OP_SUB,  11'h7FF, 1'b1, 1'b0, V_SUB};
    vecs[6]  = '{"SUBI",    OP_SUBI, 11'h001, 1'b0, 1'b0, V_SUBI};
    vecs[7]  = '{"JMP",     OP_JMP,  11'h400, 1'b0, 1'b0, V_JUMP};
    vecs[8]  = '{"NOP_0F",  5'b01111, 11'h000, 1'b1, 1'b0, V_NOP};
    vecs[9]  = '{"NOP_1F",  5'b11111, 11'h7FF, 1'b0, 1'b1, V_NOP};
    vecs[10] = '{"BEQ_Z1",  OP_BEQ,  11'h3F0, 1'b1, 1'b0, V_JUMP};
    vecs[11] = '{"BEQ_Z0",  OP_BEQ,  11'h3F0, 1'b0, 1'b0, V_NOP};

    // Bit c of each entry: taken for flag combo c, where combos are ZN = 00, 01, 10.
    taken_tbl[0] = 3'b100;  // BEQ
    taken_tbl[1] = 3'b011;  // BNE
    taken_tbl[2] = 3'b001;  // BGT
    taken_tbl[3] = 3'b101;  // BGE
    taken_tbl[4] = 3'b010;  // BLT
    taken_tbl[5] = 3'b110;  // BLE
    zn_tbl[0] = 2'b00;
    zn_tbl[1] = 2'b01;
    zn_tbl[2] = 2'b10;

    prog_op[0] = OP_LDI;  prog[0] = 11'h005;
    prog_op[1] = OP_ADDI; prog[1] = 11'h003;
    prog_op[2] = OP_STO;  prog[2] = 11'h010;
    prog_op[3] = OP_HLT;  prog[3] = 11'h000;
    exp_prog[0] = V_FETCH; exp_prog[1] = V_LDI;
    exp_prog[2] = V_FETCH; exp_prog[3] = V_ADDI;
    exp_prog[4] = V_FETCH; exp_prog[5] = V_STO;
    exp_prog[6] = V_FETCH; exp_prog[7] = V_ZERO;
    for (int k = 8; k < 12; k++) exp_prog[k] = V_HALT;

    bus.instr_i    = '0;
    bus.status_z_i = 1'b0;
    bus.status_n_i = 1'b0;

    #12;
    check("reset_outputs", {21'd0, outs()}, {21'd0, V_ZERO});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      exec_instr(vecs[i].name, vecs[i].op, vecs[i].operand, vecs[i].z, vecs[i].n, vecs[i].exp);

    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < 3; c++) begin
        logic [10:0] e;
        logic [4:0]  op;
        logic [2:0]  row;
        row = taken_tbl[b];
        op  = OP_BEQ + 5'(b);
        e   = row[c] ? V_JUMP : V_NOP;
        exec_instr($sformatf("br%0d_zn%0d", b, c), op, 11'h2AA, zn_tbl[c][1], zn_tbl[c][0], e);
      end
    end

    // Reset pulse in the middle of an ADD execute cycle.
    bus.instr_i    = {OP_ADD, 11'h044};
    bus.status_z_i = 1'b0;
    bus.status_n_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_exec_reset", {21'd0, outs()}, {21'd0, V_ZERO});
    #2 rst_n = 1'b1;
    #1 check("post_reset_fetch", {21'd0, outs()}, {21'd0, V_FETCH});

    // Program run from a clean reset, cycle by cycle.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pcen_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      logic [10:0] v;
      if ((k % 2) == 0 && k < 8) bus.instr_i = {prog_op[k/2], prog[k/2]};
      #1;
      v = outs();
      check($sformatf("prog_cycle%0d", k), {21'd0, v}, {21'd0, exp_prog[k]});
      if (v[9]) pcen_cnt++;
      @(negedge clk);
    end
    check("prog_pc_enable_count", pcen_cnt, 32'd3);

`ifdef BIP2_SINGLE_STEP_EN
    begin
      int ir_cnt;
      rst_n = 1'b0;
      step  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
        #1 check($sformatf("step_hold%0d", k), {21'd0, outs()}, {21'd0, V_ZERO});
        @(negedge clk);
      end
      bus.instr_i = {OP_LDI, 11'h001};
      ir_cnt   = 0;
      pcen_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        logic [10:0] v;
        step = (k == 0);
        #1;
        v = outs();
        if (v[10]) ir_cnt++;
        if (v[9]) pcen_cnt++;
        @(negedge clk);
      end
      check("step_ir_load_count", ir_cnt, 32'd1);
      check("step_pc_enable_count", pcen_cnt, 32'd1);
    end
`endif

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip2_control_unit.md
Name: bip2_control_unit

Overview:
- Multi-cycle control FSM for the BIP-2 core.
- Sequences the program counter: `pc_enable_o` is the PC load strobe and `pc_sel_o` is the next-PC mux select.
- Drives accumulator, ALU, data RAM and STATUS-register strobes from the opcode of the fetched instruction.
- Sits between instruction memory and the PC / datapath; every instruction takes a fixed two cycles.

Parameters:
- OPCODE_W, 5, opcode width, instr_i[15:11].
- ADDR_W, 11, operand/address width, instr_i[10:0]; matches the PC width.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- instr_i  in  OPCODE_W+ADDR_W  instruction-memory read data at the current PC.
- status_z_i  in  1  STATUS zero flag.
- status_n_i  in  1  STATUS negative flag.
- ir_load_o  out  1  instruction-register load strobe.
- pc_enable_o  out  1  PC load enable.
- pc_sel_o  out  1  next-PC select: 0 = PC+1, 1 = operand (branch/jump target).
- acc_write_o  out  1  accumulator write enable.
- acc_src_o  out  2  accumulator source: 00 = ALU, 01 = RAM, 10 = immediate.
- alu_sub_o  out  1  ALU function: 0 = add, 1 = subtract.
- alu_src_o  out  1  ALU operand B: 0 = RAM, 1 = immediate.
- ram_write_o  out  1  data RAM write enable.
- status_write_o  out  1  STATUS register update strobe.
- halted_o  out  1  core halted.

Behaviour:
- States: FETCH, EXEC, HALT.
- Reset (reset_n_i low, asynchronous): state = FETCH, internal opcode register = 0, all outputs 0. Reset is honoured in any state, including mid-EXEC and HALT.
- FETCH (1 cycle):
  - ir_load_o = 1.
  - Opcode register captures instr_i[15:11] on the clock edge.
  - All other outputs 0.
  - Next state: EXEC.
- EXEC (1 cycle): outputs decoded combinationally from the latched opcode, so they depend only on that opcode and the flags.
  - Every opcode except HLT: pc_enable_o = 1. pc_sel_o = 0 unless a branch is taken.
  - Next state: FETCH, or HALT for HLT.
- Opcode decode:
  - 00000 HLT: no strobes, pc_enable_o = 0.
  - 00001 STO: ram_write_o.
  - 00010 LD: acc_write_o, acc_src_o = 01.
  - 00011 LDI: acc_write_o, acc_src_o = 10.
  - 00100 ADD: acc_write_o, acc_src_o = 00, status_write_o.
  - 00101 ADDI: as ADD, plus alu_src_o = 1.
  - 00110 SUB: as ADD, plus alu_sub_o = 1.
  - 00111 SUBI: as SUB, plus alu_src_o = 1.
  - 01000 BEQ: taken when Z.
  - 01001 BNE: taken when !Z.
  - 01010 BGT: taken when !Z & !N.
  - 01011 BGE: taken when !N.
  - 01100 BLT: taken when N.
  - 01101 BLE: taken when N | Z.
  - 01110 JMP: always taken.
  - 01111–11111: NOP, PC advances only.
  - Taken branch: pc_sel_o = 1.
- Flag sampling: status flags are sampled during EXEC. A STATUS update by instruction k is visible to a branch at instruction k+1, because the write happens at the EXEC edge and k+1's EXEC is two cycles later.
- HALT: halted_o = 1, all strobes 0. Exit only by reset.
- PC wrap at 2^ADDR_W − 1 is the PC's concern; the control unit is unaffected.

Optional Feature:
- Macro: BIP2_SINGLE_STEP_EN.
- Defined:
  - Extra input port step_i (1 bit).
  - FETCH holds, with ir_load_o = 0, until step_i = 1 is sampled. One instruction executes per step_i high cycle.
  - step_i held high runs at full speed.
  - step_i is ignored in EXEC and HALT.
- Undefined: no step_i port; FETCH always advances.

Decomposition:
- Package bip2_pkg:
  - Opcode localparams (OP_HLT … OP_JMP).
  - acc_src encodings (ACC_SRC_ALU / ACC_SRC_RAM / ACC_SRC_IMM).
  - State enum encoding.
  - OPCODE_W and ADDR_W defaults.
- Sub-module bip2_branch_eval: combinational; inputs opcode, Z, N; outputs taken. Instantiated once inside the control unit.

Test Plan:
- Reset mid-EXEC of ADD: assert reset_n_i low for 3 ns → all outputs 0 immediately; after release, the first cycle has ir_load_o = 1.
- Program LDI 5; ADDI 3; STO 0x010; HLT → per 2-cycle slot:
  - LDI: acc_src_o = 10.
  - ADDI: alu_src_o = 1, status_write_o = 1.
  - STO: ram_write_o = 1.
  - HLT: halted_o = 1 from cycle 8 onward; pc_enable_o pulses exactly 3 times.
- BEQ 0x3F0 with Z = 1 → EXEC shows pc_enable_o = 1, pc_sel_o = 1. Same instruction with Z = 0 → pc_sel_o = 0.
- Sweep all 6 conditional branches × {Z,N} ∈ {00, 01, 10} → pc_sel_o matches the taken table; 18 checks.
- Opcode 11111 → NOP: only pc_enable_o = 1 (pc_sel_o = 0) in EXEC, no other strobes.
- With BIP2_SINGLE_STEP_EN: step_i low for 10 cycles → stays in FETCH with no strobes; a one-cycle step_i pulse → exactly one ir_load_o and one pc_enable_o.
